// File: rtl/spi_controller.sv
// Single-frame SPI mode-0 controller: 16-bit {wr, addr, wdata} frame, MSB first, CIPO captured into rdata.
// Latency: busy for 34*CLK_DIV cycles per frame; start is honoured only while idle (no queueing).
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       spi_sclk,
    output logic       spi_copi,
    output logic       spi_ncs,
    input  logic       spi_cipo
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOW  = 3'd1,
        HIGH = 3'd2,
        HOLD = 3'd3,
        GAP  = 3'd4
    } state_t;

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [1:0]  sync_q, sync_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        sclk_q, sclk_d;
    logic        copi_q, copi_d;
    logic        ncs_q, ncs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        sync_d  = {sync_q[0], spi_cipo};
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOW;
                    phase_d = DIV_M1;
                    bit_d   = 4'd0;
                    tx_d    = {wr, addr, wdata};
                end
            end
            LOW: begin
                if (phase_q == 8'd0) begin
                    state_d = HIGH;
                    phase_d = DIV_M1;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            HIGH: begin
                if (phase_q == 8'd0) begin
                    // Sample CIPO and advance COPI together as SCLK falls.
                    rx_d    = {rx_q[6:0], sync_q[1]};
                    tx_d    = {tx_q[14:0], 1'b0};
                    phase_d = DIV_M1;
                    if (bit_q == 4'd15) begin
                        state_d = HOLD;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = LOW;
                    end
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            HOLD: begin
                if (phase_q == 8'd0) begin
                    state_d = GAP;
                    phase_d = DIV_M1;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            GAP: begin
                if (phase_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        busy_d  = (state_d != IDLE);
        sclk_d  = (state_d == HIGH);
        ncs_d   = !((state_d == LOW) || (state_d == HIGH) || (state_d == HOLD));
        copi_d  = ((state_d == LOW) || (state_d == HIGH)) ? tx_d[15] : 1'b0;
        done_d  = (state_d == GAP) && (phase_d == 8'd0);
        rdata_d = done_d ? rx_d : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 8'd0;
            bit_q   <= 4'd0;
            tx_q    <= 16'd0;
            rx_q    <= 8'd0;
            sync_q  <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'd0;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
        end else begin
            phase_q <= phase_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sync_q  <= sync_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            ncs_q   <= ncs_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign spi_sclk = sclk_q;
    assign spi_copi = copi_q;
    assign spi_ncs  = ncs_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: three instances (CLK_DIV 4, 5, 255) with a mode-0 peripheral model each.
`timescale 1ns/1ps
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst[3];
    logic       start[3];
    logic       wr[3];
    logic [6:0] addr[3];
    logic [7:0] wdata[3];
    logic       busy[3];
    logic       done[3];
    logic [7:0] rdata[3];
    logic       sclk[3];
    logic       copi[3];
    logic       ncs[3];
    logic       cipo[3] = '{default: 1'b0};
    logic [15:0] miso_pat[3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DIV = (g == 0) ? 4 : (g == 1) ? 5 : 255;
        spi_controller #(.CLK_DIV(DIV)) u_dut (
            .clk(clk), .rst(rst[g]), .start(start[g]), .wr(wr[g]),
            .addr(addr[g]), .wdata(wdata[g]), .busy(busy[g]), .done(done[g]),
            .rdata(rdata[g]), .spi_sclk(sclk[g]), .spi_copi(copi[g]),
            .spi_ncs(ncs[g]), .spi_cipo(cipo[g])
        );
    end

    // Monitor / peripheral model state, one slot per instance.
    logic        ncs_prev[3]  = '{default: 1'b1};
    logic        sclk_prev[3] = '{default: 1'b0};
    logic        copi_prev[3] = '{default: 1'b0};
    logic        busy_prev[3] = '{default: 1'b0};
    int          ncs_run[3]   = '{default: 0};
    int          last_ncs_low[3] = '{default: 0};
    int          gap_run[3]   = '{default: 0};
    int          last_gap[3]  = '{default: 0};
    int          busy_run[3]  = '{default: 0};
    int          last_busy[3] = '{default: 0};
    int          rises[3]     = '{default: 0};
    int          done_cnt[3]  = '{default: 0};
    int          hi_run[3]    = '{default: 0};
    int          lo_run[3]    = '{default: 0};
    int          hi_min[3]    = '{default: 99999};
    int          hi_max[3]    = '{default: 0};
    int          lo_min[3]    = '{default: 99999};
    int          lo_max[3]    = '{default: 0};
    int          copi_bad[3]  = '{default: 0};
    int          cidx[3]      = '{default: -1};
    logic [15:0] copi_word[3] = '{default: 16'h0};
    logic [7:0]  regs[3][128] = '{default: '{default: 8'hEE}};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!ncs[i]) begin
                if (ncs_prev[i]) begin
                    ncs_run[i]   <= 1;
                    last_gap[i]  <= gap_run[i];
                    rises[i]     <= 0;
                    copi_word[i] <= 16'h0;
                    cipo[i]      <= miso_pat[i][15];
                    cidx[i]      <= 14;
                end else begin
                    ncs_run[i] <= ncs_run[i] + 1;
                end
            end else begin
                if (!ncs_prev[i]) begin
                    gap_run[i]      <= 1;
                    last_ncs_low[i] <= ncs_run[i];
                    cipo[i]         <= 1'b0;
                    cidx[i]         <= -1;
                    if (rises[i] == 16 && copi_word[i][15])
                        regs[i][copi_word[i][14:8]] <= copi_word[i][7:0];
                end else begin
                    gap_run[i] <= gap_run[i] + 1;
                end
            end
            if (sclk[i] && !sclk_prev[i]) begin
                rises[i]     <= rises[i] + 1;
                copi_word[i] <= {copi_word[i][14:0], copi[i]};
                if (lo_run[i] < lo_min[i]) lo_min[i] <= lo_run[i];
                if (lo_run[i] > lo_max[i]) lo_max[i] <= lo_run[i];
                lo_run[i] <= 0;
            end else if (!sclk[i] && !ncs[i]) begin
                lo_run[i] <= lo_run[i] + 1;
            end else if (ncs[i]) begin
                lo_run[i] <= 0;
            end
            if (!sclk[i] && sclk_prev[i]) begin
                if (hi_run[i] < hi_min[i]) hi_min[i] <= hi_run[i];
                if (hi_run[i] > hi_max[i]) hi_max[i] <= hi_run[i];
                hi_run[i] <= 0;
                if (cidx[i] >= 0 && !ncs[i]) begin
                    cipo[i] <= miso_pat[i][cidx[i]];
                    cidx[i] <= cidx[i] - 1;
                end
            end
            if (sclk[i]) begin
                hi_run[i] <= hi_run[i] + 1;
                if (sclk_prev[i] && copi[i] != copi_prev[i]) copi_bad[i] <= copi_bad[i] + 1;
            end
            if (busy[i]) begin
                busy_run[i] <= busy_run[i] + 1;
            end else if (busy_prev[i]) begin
                last_busy[i] <= busy_run[i];
                busy_run[i]  <= 0;
            end
            if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
            ncs_prev[i]  <= ncs[i];
            sclk_prev[i] <= sclk[i];
            copi_prev[i] <= copi[i];
            busy_prev[i] <= busy[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int i, input logic w, input logic [6:0] a, input logic [7:0] d);
        wr[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
        start[i] = 1'b1;
        tick(1);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, input string tag);
        int n0 = done_cnt[i];
        int k  = 0;
        while (done_cnt[i] == n0 && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, (k >= budget) ? 1 : 0, 0);
    endtask

    task automatic wait_rises(input int i, input int n, input int budget, input string tag);
        int k = 0;
        while (rises[i] != n && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, (k >= budget) ? 1 : 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; wr[i] = 1'b0;
            addr[i] = 7'h0; wdata[i] = 8'h0; miso_pat[i] = 16'h0;
        end
        // Start held during reset must not launch a frame.
        start[0] = 1'b1; wr[0] = 1'b1; addr[0] = 7'h33; wdata[0] = 8'h11;
        tick(3);
        check("rst_ncs", ncs[0], 1);
        check("rst_sclk", sclk[0], 0);
        check("rst_copi", copi[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_done", done[0], 0);
        check("rst_rdata", rdata[0], 8'h00);
        start[0] = 1'b0;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        tick(2);
        check("rst_start_ignored", busy[0], 0);

        // Basic write frame at CLK_DIV=4.
        pulse_start(0, 1'b1, 7'h00, 8'hA5);
        check("wr_busy_up", busy[0], 1);
        check("wr_ncs_low", ncs[0], 0);
        check("wr_copi_msb", copi[0], 1);
        wait_done(0, 500, "wr_done_tmo");
        check("wr_busy_at_done", busy[0], 1);
        check("wr_ncs_at_done", ncs[0], 1);
        tick(1);
        check("wr_busy_after", busy[0], 0);
        check("wr_done_pulse", done[0], 0);
        tick(3);
        check("wr_copi_word", copi_word[0], 16'h80A5);
        check("wr_rises", rises[0], 16);
        check("wr_ncs_len", last_ncs_low[0], 132);
        check("wr_busy_len", last_busy[0], 136);
        check("wr_done_cnt", done_cnt[0], 1);
        check("wr_reg0", regs[0][0], 8'hA5);
        check("wr_copi_stable", copi_bad[0], 0);
        check("wr_rdata", rdata[0], 8'h00);

        // Start during a frame is dropped.
        pulse_start(0, 1'b1, 7'h04, 8'h7F);
        wait_rises(0, 6, 200, "ign_rise_tmo");
        pulse_start(0, 1'b1, 7'h05, 8'h00);
        wait_done(0, 500, "ign_done_tmo");
        tick(40);
        check("ign_done_cnt", done_cnt[0], 2);
        check("ign_copi_word", copi_word[0], 16'h847F);
        check("ign_reg4", regs[0][4], 8'h7F);
        check("ign_reg5", regs[0][5], 8'hEE);
        check("ign_ncs_idle", ncs[0], 1);
        check("ign_busy_idle", busy[0], 0);

        // Reset during HIGH phase of bit 7.
        pulse_start(0, 1'b1, 7'h06, 8'h55);
        wait_rises(0, 8, 200, "rst_rise_tmo");
        check("mid_sclk_high", sclk[0], 1);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        check("mid_ncs", ncs[0], 1);
        check("mid_sclk", sclk[0], 0);
        check("mid_busy", busy[0], 0);
        tick(150);
        check("mid_no_done", done_cnt[0], 2);
        check("mid_rdata", rdata[0], 8'h00);
        check("mid_reg6", regs[0][6], 8'hEE);

        // Read frame with peripheral returning 16'h00C3.
        miso_pat[0] = 16'h00C3;
        pulse_start(0, 1'b0, 7'h10, 8'h00);
        wait_done(0, 500, "rd_done_tmo");
        check("rd_rdata", rdata[0], 8'hC3);
        check("rd_copi_word", copi_word[0], 16'h1000);

        // Back-to-back frames at CLK_DIV=5.
        pulse_start(1, 1'b1, 7'h01, 8'hFF);
        wait_done(1, 500, "b2b_done1_tmo");
        check("b2b_ncs_len1", last_ncs_low[1], 165);
        @(posedge clk);
        #1;
        wr[1] = 1'b1; addr[1] = 7'h02; wdata[1] = 8'h00; start[1] = 1'b1;
        @(posedge clk);
        #1;
        start[1] = 1'b0;
        wait_done(1, 500, "b2b_done2_tmo");
        tick(3);
        check("b2b_gap", last_gap[1], 6);
        check("b2b_ncs_len2", last_ncs_low[1], 165);
        check("b2b_reg1", regs[1][1], 8'hFF);
        check("b2b_reg2", regs[1][2], 8'h00);
        check("b2b_done_cnt", done_cnt[1], 2);

        // Maximum divider.
        pulse_start(2, 1'b1, 7'h3C, 8'h96);
        wait_done(2, 10000, "max_done_tmo");
        tick(3);
        check("max_ncs_len", last_ncs_low[2], 8415);
        check("max_busy_len", last_busy[2], 8670);
        check("max_hi_min", hi_min[2], 255);
        check("max_hi_max", hi_max[2], 255);
        check("max_lo_min", lo_min[2], 255);
        check("max_lo_max", lo_max[2], 255);
        check("max_rises", rises[2], 16);
        check("max_copi_word", copi_word[2], 16'hBC96);
        check("max_reg", regs[2][7'h3C], 8'h96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter CLK_DIV, default 4, gives the clk cycles per SCLK half-period; the legal range is 4..255.
REQ-002 clk  input  1  single clock; all logic is clocked on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle request to send one frame; sampled only while busy=0.
REQ-005 wr  input  1  frame command bit: 1=write, 0=read; latched on an accepted start.
REQ-006 addr  input  7  register address; latched on an accepted start.
REQ-007 wdata  input  8  write data; latched on an accepted start.
REQ-008 busy  output  1  high while a frame is in progress.
REQ-009 done  output  1  one-cycle pulse at frame completion.
REQ-010 rdata  output  8  last 8 CIPO bits of the most recent completed frame.
REQ-011 spi_sclk  output  1  SPI clock, mode 0 (idles low).
REQ-012 spi_copi  output  1  controller-out data, MSB first.
REQ-013 spi_ncs  output  1  active-low chip select.
REQ-014 spi_cipo  input  1  peripheral-out data, asynchronous to clk.

Function
REQ-015 The frame SHALL be exactly 16 bits, transmitted MSB first: {wr, addr[6:0], wdata[7:0]}.
REQ-016 The FSM SHALL have the states IDLE, LOW, HIGH, HOLD and GAP, and a 4-bit bit counter 0..15.
REQ-017 In IDLE: spi_ncs=1, spi_sclk=0, spi_copi=0, busy=0.
REQ-018 If start=1 in IDLE, the next cycle SHALL have: state LOW, busy=1, spi_ncs=0, spi_copi=frame[15], bit counter=0, shift register loaded.
REQ-019 A start while busy=1 SHALL be ignored, with no latching and no queueing.
REQ-020 The LOW phase SHALL last CLK_DIV cycles with spi_sclk=0, then go to HIGH.
REQ-021 The HIGH phase SHALL last CLK_DIV cycles with spi_sclk=1, and spi_copi SHALL be stable for the whole phase.
REQ-022 spi_cipo SHALL pass through a 2-flop synchronizer, and the synchronized value SHALL be shifted into the receive register on the last clk cycle of each HIGH phase.
REQ-023 At the end of HIGH with bit counter<15: the counter SHALL increment, the state SHALL go to LOW, and spi_copi SHALL present the next bit in the same cycle spi_sclk falls.
REQ-024 At the end of HIGH with bit counter=15: the state SHALL go to HOLD, with spi_sclk=0 and spi_ncs=0 for CLK_DIV cycles.
REQ-025 After HOLD, the state SHALL go to GAP: spi_ncs=1, spi_copi=0, for CLK_DIV cycles.
REQ-026 done SHALL be high only on the last GAP cycle; rdata SHALL update on that same cycle; busy SHALL fall on the next cycle, when the state is IDLE.
REQ-027 Per-frame timing: spi_ncs low for exactly 33*CLK_DIV cycles; 16 SCLK rising edges; busy high for 34*CLK_DIV cycles.
REQ-028 A start in the cycle after done SHALL be accepted, giving back-to-back frames with spi_ncs high for at least CLK_DIV+1 cycles between them.
REQ-029 Phase counters SHALL be sized for CLK_DIV=255 without wrap, and SHALL count from CLK_DIV-1 down to 0.
REQ-030 All outputs SHALL be registered, with no combinational path from an input to any SPI pin.

Reset
REQ-031 With rst=1 at a clk edge: state=IDLE, spi_ncs=1, spi_sclk=0, spi_copi=0, busy=0, done=0, rdata=8'h00, shift registers, counters and synchronizer=0.
REQ-032 Reset mid-frame SHALL raise spi_ncs on the following cycle and produce no done pulse; a truncated frame SHALL NOT update rdata.
REQ-033 A start asserted during rst=1 SHALL be ignored.

Verification
REQ-034 CLK_DIV=4, start with wr=1, addr=7'h00, wdata=8'hA5 -> COPI bits sampled at the 16 SCLK rising edges equal 16'h80A5; spi_ncs low 132 cycles; one done pulse; a 16-bit mode-0 peripheral model stores 8'hA5 at address 0.
REQ-035 Write addr=7'h04, wdata=8'h7F, then a second start pulsed at bit 5 of that frame -> the second start is ignored; exactly one frame and one done occur.
REQ-036 spi_cipo driven by a model shifting 16'h00C3 on SCLK falling edges, wr=0 -> at done, rdata=8'hC3; the COPI MSB is 0.
REQ-037 rst pulsed for 1 cycle during the HIGH phase of bit 7 -> the next cycle has spi_ncs=1, spi_sclk=0, busy=0; no done; rdata unchanged at 8'h00.
REQ-038 Two frames (addr 7'h01/8'hFF, then 7'h02/8'h00), with the second start in the cycle after done, CLK_DIV=5 -> the gap is 6 cycles with spi_ncs high; each frame has spi_ncs low for 165 cycles; the model registers hold 8'hFF and 8'h00.
REQ-039 CLK_DIV=255 single frame -> spi_ncs low for 8415 cycles; each SCLK phase lasts 255 cycles; no counter wrap.
